aes_key_schedule_ctrl: RTL and testbench

- Sequencer that drives the single-round key expansion stage (aes_key_expand_revamped) over all AES-128 rounds.
- Accepts a 128-bit cipher key through a valid/ready handshake and supplies the expander's key_in and rnd_constant each round.
- Captures each expander key_out into an 11-entry round-key register file.
- Exposes the round keys to the cipher datapath through a registered read port and flags completion.

---
 rtl/aes_key_schedule_ctrl_if.sv | 19 +
 rtl/aes_key_schedule_ctrl.sv | 128 ++++++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_ctrl_if.sv
// Cipher-key valid/ready handshake between a key source and the
// AES-128 key-schedule sequencer. master = key source, slave = sequencer.
interface aes_key_schedule_ctrl_if;
   logic         key_valid;
   logic         key_ready;
   logic [127:0] key_in;

   modport master (
      output key_valid,
      output key_in,
      input  key_ready
   );

   modport slave (
      input  key_valid,
      input  key_in,
      output key_ready
   );
endinterface

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key-schedule sequencer: drives a one-round key expander over all
// rounds and keeps every round key in a register file.
// Ports: clk, rst_n (sync, active-low); key_if (key handshake, slave);
//   exp_key_in/exp_rnd_constant -> expander, exp_key_out <- expander;
//   busy, done (pulse), keys_valid (level); rk_rd_idx -> rk_rd_data (1-cycle).
module aes_key_schedule_ctrl #(
   parameter int NUM_ROUNDS = 10,
   parameter int IDX_W      = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   aes_key_schedule_ctrl_if.slave key_if,
   output logic [127:0]         exp_key_in,
   output logic [31:0]          exp_rnd_constant,
   input  logic [127:0]         exp_key_out,
   output logic                 busy,
   output logic                 done,
   output logic                 keys_valid,
   input  logic [IDX_W-1:0]     rk_rd_idx,
   output logic [127:0]         rk_rd_data
);

   localparam int RW = $clog2(NUM_ROUNDS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_FIN
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [RW-1:0]   round;
   logic [127:0]    rk [0:NUM_ROUNDS];
   logic            hs;
   logic            last;

   // Round constant by repeated doubling in GF(2^8).
   function automatic logic [7:0] rcon(input logic [RW-1:0] r);
      logic [7:0] v;
      v = 8'h01;
      for (int i = 1; i < (1 << RW); i++) begin
         if (i < int'(r)) begin
            v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
         end
      end
      return v;
   endfunction

   assign hs   = key_if.key_valid && key_if.key_ready;
   assign last = (round == RW'(NUM_ROUNDS));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:    if (hs) state_nxt = S_ISSUE;
         S_ISSUE:   state_nxt = S_CAPTURE;
         S_CAPTURE: state_nxt = last ? S_FIN : S_ISSUE;
         S_FIN:     state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      key_if.key_ready = rst_n && (state == S_IDLE);
      busy             = (state != S_IDLE);
      done             = (state == S_FIN);
   end

   // Expander inputs are loaded one edge ahead so they sit stable
   // through both ISSUE and CAPTURE of a round.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         round            <= '0;
         keys_valid       <= 1'b0;
         exp_key_in       <= '0;
         exp_rnd_constant <= '0;
         for (int i = 0; i <= NUM_ROUNDS; i++) begin
            rk[i] <= '0;
         end
      end else begin
         unique case (state)
            S_IDLE: begin
               if (hs) begin
                  rk[0]            <= key_if.key_in;
                  round            <= RW'(1);
                  keys_valid       <= 1'b0;
                  exp_key_in       <= key_if.key_in;
                  exp_rnd_constant <= {24'h0, rcon(RW'(1))};
               end
            end
            S_CAPTURE: begin
               rk[round] <= exp_key_out;
               if (last) begin
                  keys_valid       <= 1'b1;
                  exp_key_in       <= '0;
                  exp_rnd_constant <= '0;
               end else begin
                  round            <= round + RW'(1);
                  exp_key_in       <= exp_key_out;
                  exp_rnd_constant <= {24'h0, rcon(round + RW'(1))};
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rk_rd_data <= '0;
      end else if (int'(rk_rd_idx) <= NUM_ROUNDS) begin
         rk_rd_data <= rk[rk_rd_idx];
      end else begin
         rk_rd_data <= '0;
      end
   end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Bench for aes_key_schedule_ctrl: models the registered-g expander and
// checks schedules against a word-level FIPS-197 key expansion.
module tb_aes_key_schedule_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic [127:0] exp_key_in;
   logic [31:0]  exp_rnd_constant;
   logic [127:0] exp_key_out;
   logic         busy;
   logic         done;
   logic         keys_valid;
   logic [3:0]   rk_rd_idx;
   logic [127:0] rk_rd_data;

   aes_key_schedule_ctrl_if kif ();

   aes_key_schedule_ctrl #(
      .NUM_ROUNDS (10),
      .IDX_W      (4)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .key_if           (kif),
      .exp_key_in       (exp_key_in),
      .exp_rnd_constant (exp_rnd_constant),
      .exp_key_out      (exp_key_out),
      .busy             (busy),
      .done             (done),
      .keys_valid       (keys_valid),
      .rk_rd_idx        (rk_rd_idx),
      .rk_rd_data       (rk_rd_data)
   );

   int n_tests  = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   logic [7:0]   sbox_t [0:255];
   logic [127:0] mrk [0:10];
   logic [31:0]  g_q;

   localparam logic [127:0] FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = xt(a);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [7:0] r;
      r = (b << n) | (b >> (8 - n));
      return r;
   endfunction

   // S-box from the multiplicative inverse plus affine map.
   task automatic fill_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         if (x != 0) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
         end
         sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^
                     rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]],
              sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   function automatic logic [31:0] gfun(input logic [31:0] w, input logic [7:0] rc);
      return subw({w[23:0], w[31:24]}) ^ {rc, 24'h0};
   endfunction

   function automatic logic [127:0] xout(input logic [127:0] k, input logic [31:0] g);
      logic [31:0] w0, w1, w2, w3;
      w0 = k[127:96] ^ g;
      w1 = k[95:64] ^ w0;
      w2 = k[63:32] ^ w1;
      w3 = k[31:0] ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   // Expander model: g registered, so key_out is right only in 2nd cycle.
   always_ff @(posedge clk) g_q <= gfun(exp_key_in[31:0], exp_rnd_constant[7:0]);
   assign exp_key_out = xout(exp_key_in, g_q);

   function automatic logic [7:0] rc_n(input int n);
      logic [7:0] r;
      r = 8'h01;
      for (int i = 1; i < n; i++) r = xt(r);
      return r;
   endfunction

   function automatic void model_expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) mrk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (done === 1'b1) done_cnt++;
   endtask

   task automatic wait_ready();
      int w;
      w = 0;
      while (kif.key_ready !== 1'b1 && w < 50) begin
         step();
         w++;
      end
      check("ready_wait", 128'(w < 50), 128'(1));
   endtask

   // Handshake, then follow ISSUE/CAPTURE pairs up to the done pulse.
   task automatic run_key(input logic [127:0] key, input bit inject);
      logic [127:0] sk;
      logic [31:0]  sr;
      int           t;
      kif.key_valid = 1'b1;
      kif.key_in    = key;
      wait_ready();
      step();
      kif.key_valid = 1'b0;
      kif.key_in    = {$urandom, $urandom, $urandom, $urandom};
      model_expand(key);
      check("kv_drop", 128'(keys_valid), 128'(0));
      sk = '0;
      sr = '0;
      t  = 1;
      while (done !== 1'b1 && t <= 40) begin
         check($sformatf("ready_low_t%0d", t), 128'(kif.key_ready), 128'(0));
         check($sformatf("busy_t%0d", t), 128'(busy), 128'(1));
         if (t % 2 == 1) begin
            sk = exp_key_in;
            sr = exp_rnd_constant;
            if (t <= 19) begin
               check($sformatf("xkey_t%0d", t), exp_key_in, mrk[(t-1)/2]);
               check($sformatf("rcon_t%0d", t), 128'(exp_rnd_constant),
                     128'({24'h0, rc_n((t+1)/2)}));
            end
         end else begin
            check($sformatf("hold_key_t%0d", t), exp_key_in, sk);
            check($sformatf("hold_rc_t%0d", t), 128'(exp_rnd_constant), 128'(sr));
         end
         if (inject && t == 5) begin
            kif.key_valid = 1'b1;
            kif.key_in    = ~key;
         end
         if (t == 6) kif.key_valid = 1'b0;
         step();
         t++;
      end
      check("done_latency", 128'(t), 128'(21));
      check("kv_at_done", 128'(keys_valid), 128'(1));
      check("exp_zero_done", exp_key_in, 128'(0));
   endtask

   task automatic read_chk(input int idx, input logic [127:0] exp, input string nm);
      rk_rd_idx = 4'(idx);
      step();
      check($sformatf("%s_idx%0d", nm, idx), rk_rd_data, exp);
   endtask

   task automatic read_all(input string nm);
      for (int i = 0; i < 16; i++) read_chk(i, (i <= 10) ? mrk[i] : 128'(0), nm);
   endtask

   typedef struct {
      logic [127:0] key;
      int           idx;
      logic [127:0] exp;
   } vec_t;

   vec_t         vt [0:7];
   logic [127:0] loaded;
   logic [127:0] k;
   int           dc;

   initial begin
      vt[0] = '{FIPS, 0, FIPS};
      vt[1] = '{FIPS, 1, 128'ha0fafe1788542cb123a339392a6c7605};
      vt[2] = '{FIPS, 10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vt[3] = '{FIPS, 11, 128'h0};
      vt[4] = '{FIPS, 15, 128'h0};
      vt[5] = '{128'h0, 0, 128'h0};
      vt[6] = '{128'h0, 1, 128'h62636363626363636263636362636363};
      vt[7] = '{128'h0, 10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      fill_sbox();
      rst_n         = 1'b0;
      kif.key_valid = 1'b0;
      kif.key_in    = '0;
      rk_rd_idx     = '0;
      step();
      step();
      check("rst_ready", 128'(kif.key_ready), 128'(0));
      check("rst_busy", 128'(busy), 128'(0));
      check("rst_done", 128'(done), 128'(0));
      check("rst_kv", 128'(keys_valid), 128'(0));
      check("rst_xkey", exp_key_in, 128'(0));
      check("rst_rc", 128'(exp_rnd_constant), 128'(0));
      check("rst_rd", rk_rd_data, 128'(0));
      rst_n = 1'b1;
      step();
      check("idle_ready", 128'(kif.key_ready), 128'(1));

      // FIPS key with a stray key_valid at T5.
      dc = done_cnt;
      run_key(FIPS, 1'b1);
      check("done_once_fips", 128'(done_cnt - dc), 128'(1));
      step();
      check("ready_t22", 128'(kif.key_ready), 128'(1));
      read_all("fips");
      loaded = FIPS;

      for (int i = 0; i < 8; i++) begin
         if (loaded !== vt[i].key) begin
            run_key(vt[i].key, 1'b0);
            loaded = vt[i].key;
         end
         read_chk(vt[i].idx, vt[i].exp, $sformatf("tbl%0d", i));
      end

      // Back-to-back keys.
      dc = done_cnt;
      k  = {$urandom, $urandom, $urandom, $urandom};
      run_key(k, 1'b0);
      step();
      check("b2b_kv_t22", 128'(keys_valid), 128'(1));
      check("b2b_ready_t22", 128'(kif.key_ready), 128'(1));
      k = {$urandom, $urandom, $urandom, $urandom};
      run_key(k, 1'b0);
      check("b2b_done_cnt", 128'(done_cnt - dc), 128'(2));
      read_all("b2b");

      // Reset in the middle of an expansion.
      kif.key_valid = 1'b1;
      kif.key_in    = FIPS;
      wait_ready();
      step();
      kif.key_valid = 1'b0;
      repeat (8) step();
      dc    = done_cnt;
      rst_n = 1'b0;
      step();
      check("mid_busy", 128'(busy), 128'(0));
      check("mid_done", 128'(done), 128'(0));
      check("mid_kv", 128'(keys_valid), 128'(0));
      check("mid_xkey", exp_key_in, 128'(0));
      check("mid_rc", 128'(exp_rnd_constant), 128'(0));
      check("mid_rd", rk_rd_data, 128'(0));
      check("mid_ready", 128'(kif.key_ready), 128'(0));
      rst_n = 1'b1;
      repeat (25) step();
      check("mid_ready_after", 128'(kif.key_ready), 128'(1));
      check("mid_no_done", 128'(done_cnt - dc), 128'(0));
      check("mid_kv_after", 128'(keys_valid), 128'(0));
      read_chk(0, 128'(0), "mid_rk0");
      read_chk(1, 128'(0), "mid_rk1");
      k = {$urandom, $urandom, $urandom, $urandom};
      run_key(k, 1'b0);
      read_all("post_rst");

      for (int r = 0; r < 3; r++) begin
         k = {$urandom, $urandom, $urandom, $urandom};
         run_key(k, 1'b0);
         read_all($sformatf("rnd%0d", r));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
